// File: rtl/cheri_dmem_responder.sv
// Data-side memory responder for the CHERIoT core: req/gnt/rvalid protocol, 33-bit words with bit 32 as the capability tag.
// Optional LFSR-driven grant stalling is built only when DMEM_GNT_STALL_EN is defined.
module cheri_dmem_responder #(
  parameter logic [31:0] AddrBase       = 32'h2000_0000,
  parameter int unsigned MemWords       = 4096,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [15:0] StallSeed      = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_is_cap_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [32:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [32:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned IdxW      = $clog2(MemWords);
  localparam logic [32:0] AddrLimit = {1'b0, AddrBase} + 33'(4 * MemWords);
  localparam logic [2:0]  MaxOut    = 3'(MaxOutstanding);

  // Handshake: a request is taken on the rising edge where req and gnt are both high; gnt is
  // combinational, and exactly one rvalid pulse follows each accepted request, in grant order.

  logic [32:0]        mem [MemWords];
  logic [31:0]        addr_word;
  logic [31:0]        offset;
  logic [IdxW-1:0]    idx;
  logic               addr_err;
  logic               stall;
  logic               accept;
  logic               tag_new;
  logic [32:0]        rd_word;
  logic [32:0]        resp_data;
  logic [2:0]         out_cnt;
  logic [Latency-1:0] pipe_valid;
  logic [Latency-1:0] pipe_err;
  logic [32:0]        pipe_data [Latency];
  logic [5:0]         unused_addr_bits;

  // Compare in 33 bits so addresses near the top of the map cannot wrap into the window.
  assign addr_word = {data_addr_i[31:2], 2'b00};
  assign addr_err  = ({1'b0, addr_word} < {1'b0, AddrBase}) | ({1'b0, addr_word} >= AddrLimit);
  assign offset    = addr_word - AddrBase;
  assign idx       = offset[IdxW+1:2];
  assign unused_addr_bits = {data_addr_i[1:0], offset[1:0], ^offset[31:IdxW+2], 1'b0};

`ifdef DMEM_GNT_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= StallSeed;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  logic [15:0] unused_seed;

  assign unused_seed = StallSeed;
  assign stall       = 1'b0;
`endif

  assign data_gnt_o = data_req_i & ~rst_i & (out_cnt < MaxOut) & ~stall;
  assign accept     = data_gnt_o;

  // Loads read the array on the grant edge, so a store granted one cycle earlier is already visible.
  assign rd_word = mem[idx];
  assign tag_new = data_is_cap_i & (data_be_i == 4'hF) & data_wdata_i[32];

  always_comb begin
    resp_data = '0;
    if (!addr_err && !data_we_i) begin
      resp_data = data_is_cap_i ? rd_word : {1'b0, rd_word[31:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
      mem[idx][32] <= tag_new;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < Latency; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept & addr_err;
      pipe_data[0]  <= accept ? resp_data : 33'd0;
      for (int i = 1; i < Latency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt <= '0;
    end else begin
      case ({accept, data_rvalid_o})
        2'b10:   out_cnt <= out_cnt + 3'd1;
        2'b01:   out_cnt <= out_cnt - 3'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  assign data_rvalid_o = pipe_valid[Latency-1];
  assign data_rdata_o  = data_rvalid_o ? pipe_data[Latency-1] : 33'd0;
  assign data_err_o    = data_rvalid_o & pipe_err[Latency-1];

endmodule

// File: tb/tb_cheri_dmem_responder.sv
// Directed bench for cheri_dmem_responder: reset, load/store/tag rules, address decode,
// back-pressure on a Latency=2/MaxOutstanding=1 instance, and a short scoreboarded random run.
module tb_cheri_dmem_responder;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_bp, cap, we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [32:0] wd;
  logic        gnt, rvalid, err;
  logic [32:0] rdata;
  logic        gnt_bp, rvalid_bp, err_bp;
  logic [32:0] rdata_bp;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [32:0] r_d;
  logic        r_e;
  int          r_l;
  logic [32:0] m [16];
  logic [33:0] exp_q [$];
  logic [5:0]  exp_g  = 6'b001001;
  logic [5:0]  exp_rv = 6'b100100;
  int          out_m;
  int          g_cnt;

  always #5 clk = ~clk;

  cheri_dmem_responder dut (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_is_cap_i(cap), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wd), .data_gnt_o(gnt),
    .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err)
  );

  cheri_dmem_responder #(.Latency(2), .MaxOutstanding(1)) dut_bp (
    .clk_i(clk), .rst_i(rst), .data_req_i(req_bp), .data_is_cap_i(cap), .data_we_i(we),
    .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wd), .data_gnt_o(gnt_bp),
    .data_rvalid_o(rvalid_bp), .data_rdata_o(rdata_bp), .data_err_o(err_bp)
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic is_err(input logic [31:0] a);
    return (a < BASE) || ((a - BASE) >= 32'(4 * WORDS));
  endfunction

  // Reference behaviour for the first 16 words; returns {rdata, err} for one accepted request.
  task automatic model_op(input logic t_we, input logic t_cap, input logic [3:0] t_be,
                          input logic [31:0] t_addr, input logic [32:0] t_wd,
                          output logic [32:0] t_rd, output logic t_er);
    logic [31:0] ix;
    t_er = is_err(t_addr);
    ix   = (t_addr - BASE) >> 2;
    t_rd = '0;
    if (t_we) begin
      if (!t_er) begin
        for (int b = 0; b < 4; b++)
          if (t_be[b]) m[ix[3:0]][8*b +: 8] = t_wd[8*b +: 8];
        m[ix[3:0]][32] = (t_cap && t_be == 4'hF) ? t_wd[32] : 1'b0;
      end
    end else if (!t_er) begin
      t_rd = t_cap ? m[ix[3:0]] : {1'b0, m[ix[3:0]][31:0]};
    end
  endtask

  // One blocking transaction on the default instance; returns response and grant-to-rvalid latency.
  task automatic xact(input logic t_we, input logic t_cap, input logic [3:0] t_be,
                      input logic [31:0] t_addr, input logic [32:0] t_wd,
                      output logic [32:0] t_rd, output logic t_err, output int t_lat);
    int guard;
    @(negedge clk);
    we = t_we; cap = t_cap; be = t_be; addr = t_addr; wd = t_wd; req = 1'b1;
    #1;
    guard = 0;
    while (!gnt && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    if (!gnt) check("gnt_timeout", {32'd0, gnt}, 33'd1);
    @(posedge clk);
    @(negedge clk);
    req   = 1'b0;
    t_lat = 1;
    while (!rvalid && t_lat < 10) begin
      @(negedge clk); t_lat++;
    end
    t_rd  = rdata;
    t_err = err;
  endtask

  task automatic check_resp();
    logic [33:0] e;
    if (rvalid) begin
      if (exp_q.size() == 0) begin
        check("rnd_spurious", {32'd0, rvalid}, 33'd0);
      end else begin
        e = exp_q.pop_front();
        check("rnd_rdata", rdata, e[33:1]);
        check("rnd_err", {32'd0, err}, {32'd0, e[0]});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b1; req_bp = 1'b0; cap = 1'b0; we = 1'b0;
    be = 4'hF; addr = BASE; wd = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_gnt", {32'd0, gnt}, 33'd0);
      check("rst_rvalid", {32'd0, rvalid}, 33'd0);
      check("rst_rdata", rdata, 33'd0);
    end
    @(negedge clk);
    rst = 1'b0; req = 1'b0;

    xact(1'b0, 1'b0, 4'hF, BASE, 33'd0, r_d, r_e, r_l);
    check("load_latency", 33'(r_l), 33'd1);
    check("load_err", {32'd0, r_e}, 33'd0);

    xact(1'b1, 1'b0, 4'hF, BASE + 32'd8, 33'h1_DEADBEEF, r_d, r_e, r_l);
    check("st_rdata", r_d, 33'd0);
    check("st_err", {32'd0, r_e}, 33'd0);
    xact(1'b0, 1'b1, 4'hF, BASE + 32'd8, 33'd0, r_d, r_e, r_l);
    check("data_st_cap_ld", r_d, 33'h0_DEADBEEF);
    xact(1'b0, 1'b1, 4'hF, BASE + 32'd11, 33'd0, r_d, r_e, r_l);
    check("low_bits_ignored", r_d, 33'h0_DEADBEEF);

    xact(1'b1, 1'b1, 4'hF, BASE + 32'h10, 33'h1_12345678, r_d, r_e, r_l);
    xact(1'b0, 1'b1, 4'h0, BASE + 32'h10, 33'd0, r_d, r_e, r_l);
    check("cap_st_cap_ld", r_d, 33'h1_12345678);
    xact(1'b0, 1'b0, 4'hF, BASE + 32'h10, 33'd0, r_d, r_e, r_l);
    check("cap_st_data_ld", r_d, 33'h0_12345678);
    xact(1'b1, 1'b1, 4'b0001, BASE + 32'h10, 33'h1_000000AB, r_d, r_e, r_l);
    xact(1'b0, 1'b1, 4'hF, BASE + 32'h10, 33'd0, r_d, r_e, r_l);
    check("partial_clears_tag", r_d, 33'h0_123456AB);

    xact(1'b1, 1'b1, 4'hF, BASE, 33'h1_CAFEF00D, r_d, r_e, r_l);
    xact(1'b1, 1'b1, 4'hF, BASE + 32'(4 * WORDS), 33'h1_55555555, r_d, r_e, r_l);
    check("oor_st_err", {32'd0, r_e}, 33'd1);
    check("oor_st_rdata", r_d, 33'd0);
    xact(1'b0, 1'b1, 4'hF, BASE, 33'd0, r_d, r_e, r_l);
    check("oor_st_no_write", r_d, 33'h1_CAFEF00D);
    xact(1'b0, 1'b0, 4'hF, BASE - 32'd4, 33'd0, r_d, r_e, r_l);
    check("below_err", {32'd0, r_e}, 33'd1);
    check("below_rdata", r_d, 33'd0);
    xact(1'b1, 1'b0, 4'hF, BASE + 32'(4 * WORDS) - 32'd4, 33'h0_77777777, r_d, r_e, r_l);
    xact(1'b0, 1'b0, 4'hF, BASE + 32'(4 * WORDS) - 32'd4, 33'd0, r_d, r_e, r_l);
    check("last_word_err", {32'd0, r_e}, 33'd0);
    check("last_word_rdata", r_d, 33'h0_77777777);
    xact(1'b0, 1'b0, 4'hF, 32'hFFFF_FFFC, 33'd0, r_d, r_e, r_l);
    check("top_addr_err", {32'd0, r_e}, 33'd1);
    xact(1'b0, 1'b0, 4'hF, 32'h0000_0000, 33'd0, r_d, r_e, r_l);
    check("zero_addr_err", {32'd0, r_e}, 33'd1);

`ifndef DMEM_GNT_STALL_EN
    // Store followed by a load to the same word in the very next cycle.
    @(negedge clk);
    we = 1'b1; cap = 1'b0; be = 4'hF; addr = BASE + 32'h20; wd = 33'h0_0BADF00D; req = 1'b1;
    #1 check("b2b_st_gnt", {32'd0, gnt}, 33'd1);
    @(negedge clk);
    check("b2b_st_rvalid", {32'd0, rvalid}, 33'd1);
    we = 1'b0; cap = 1'b1;
    #1 check("b2b_ld_gnt", {32'd0, gnt}, 33'd1);
    @(negedge clk);
    req = 1'b0;
    check("b2b_ld_rvalid", {32'd0, rvalid}, 33'd1);
    check("b2b_ld_rdata", rdata, 33'h0_0BADF00D);
`endif

    // Back-pressure: Latency=2, MaxOutstanding=1, request held for six cycles.
    @(negedge clk);
    we = 1'b0; cap = 1'b0; addr = BASE + 32'd4; req_bp = 1'b1;
    out_m = 0; g_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("bp_limit", {32'd0, gnt_bp && out_m >= 1}, 33'd0);
`ifndef DMEM_GNT_STALL_EN
      check("bp_gnt", {32'd0, gnt_bp}, {32'd0, exp_g[c]});
      check("bp_rvalid", {32'd0, rvalid_bp}, {32'd0, exp_rv[c]});
`endif
      out_m = out_m + int'(gnt_bp) - int'(rvalid_bp);
      g_cnt += int'(gnt_bp);
      @(negedge clk);
    end
    req_bp = 1'b0;
    repeat (4) @(negedge clk);

    // Reset while a response is in flight discards it and frees the outstanding slot.
    req_bp = 1'b1; addr = BASE;
    @(negedge clk);
    req_bp = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_flush_0", {32'd0, rvalid_bp}, 33'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_flush_1", {32'd0, rvalid_bp}, 33'd0);
    @(negedge clk);
    check("rst_flush_2", {32'd0, rvalid_bp}, 33'd0);
`ifndef DMEM_GNT_STALL_EN
    req_bp = 1'b1;
    #1 check("rst_cnt_cleared", {32'd0, gnt_bp}, 33'd1);
    @(negedge clk);
    req_bp = 1'b0;
    repeat (4) @(negedge clk);
`endif

    // Scoreboarded random traffic over the first 16 words plus out-of-window addresses.
    for (int i = 0; i < 16; i++) begin
      xact(1'b1, 1'b1, 4'hF, BASE + 32'(4 * i), {1'(i), 32'hA500_0000 + 32'(i)}, r_d, r_e, r_l);
      model_op(1'b1, 1'b1, 4'hF, BASE + 32'(4 * i), {1'(i), 32'hA500_0000 + 32'(i)}, r_d, r_e);
    end
    for (int n = 0; n < 300; n++) begin
      int sel;
      @(negedge clk);
      check_resp();
      req = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      cap = 1'($urandom_range(0, 1));
      be  = 4'($urandom_range(0, 15));
      wd  = {1'($urandom_range(0, 1)), 32'($urandom)};
      sel = $urandom_range(0, 9);
      case (sel)
        0:       addr = BASE - 32'd4;
        1:       addr = BASE + 32'(4 * WORDS);
        2:       addr = 32'hFFFF_FFFC;
        default: addr = BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      addr = addr + 32'($urandom_range(0, 3));
      #1;
      if (req && gnt) begin
        model_op(we, cap, be, addr, wd, r_d, r_e);
        exp_q.push_back({r_d, r_e});
      end
    end
    @(negedge clk);
    check_resp();
    req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_resp();
    end
    check("rnd_drain", 33'(exp_q.size()), 33'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
